shiftreg_serializer: RTL and testbench

SHIFTREG_SERIALIZER -- requirements
Module: shiftreg_serializer

---
 rtl/shiftreg_pkg.sv | 23 ++
 rtl/shiftreg_serializer.sv | 83 ++++++++
 tb/tb_shiftreg_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared widths, types and helpers for the shift-register serializer.
package shiftreg_pkg;

    localparam int unsigned OutputWidth = 13;
    localparam int unsigned Stage1Width = 5;
    localparam int unsigned ChunkWidth  = Stage1Width;
    localparam int unsigned NumChunks   = (OutputWidth + ChunkWidth - 1) / ChunkWidth;
    localparam int unsigned CounterWidth = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    typedef logic [ChunkWidth-1:0]   chunk_type;
    typedef logic [CounterWidth-1:0] counter_type;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Integer ceiling division used for chunk-count derivation.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/shiftreg_serializer.sv
// Parallel-to-serial converter: emits a word as LSB-first chunks with
// ready/valid handshakes on both sides and a last-chunk marker.
module shiftreg_serializer #(
    parameter int unsigned InputWidth = shiftreg_pkg::OutputWidth,
    parameter int unsigned ChunkWidth = shiftreg_pkg::Stage1Width
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [InputWidth-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ChunkWidth-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);
    import shiftreg_pkg::*;

    localparam int unsigned NChunks    = ceil_div(InputWidth, ChunkWidth);
    localparam int unsigned ShiftWidth = NChunks * ChunkWidth;
    localparam int unsigned CntWidth   = (NChunks > 1) ? $clog2(NChunks) : 1;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ShiftWidth-1:0] shift_q, shift_d;

    logic is_last;
    logic out_hs;
    logic accept;

    assign is_last = (cnt_q == CntWidth'(NChunks - 1));

    assign valid_o = (state_q == SHIFT);
    assign last_o  = valid_o && is_last;
    assign data_o  = shift_q[ChunkWidth-1:0];
    assign out_hs  = valid_o && ready_i;

    // Reset is folded in so ready_o reads low while the block is held in reset.
    assign ready_o = !rst_i && !clear_i && ((state_q == IDLE) || (out_hs && is_last));
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;

        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            if (out_hs) begin
                shift_d = shift_q >> ChunkWidth;
                if (is_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            // A new word may land on the same edge as the final-chunk handshake.
            if (accept) begin
                state_d = SHIFT;
                cnt_d   = '0;
                shift_d = ShiftWidth'(data_i);
            end
        end
    end

endmodule

// File: tb/tb_shiftreg_serializer.sv
// Self-checking bench for shiftreg_serializer: directed scenarios plus a
// randomized run against a queue-of-chunks reference model.
module tb_shiftreg_serializer;

    localparam int unsigned IW = 13;
    localparam int unsigned CW = 5;
    localparam int unsigned NC = (IW + CW - 1) / CW;

    logic          clk_i;
    logic          rst_i;
    logic          clear_i;
    logic [IW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [CW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;

    int n_checks;
    int n_fail;

    shiftreg_serializer #(
        .InputWidth(IW),
        .ChunkWidth(CW)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .last_o (last_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Chunk n of a word, from plain arithmetic on the word value.
    function automatic logic [CW-1:0] chunk_of(input logic [IW-1:0] w, input int n);
        int unsigned v;
        v = int'(w);
        return CW'((v >> (n * CW)) % (1 << CW));
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", ready_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", valid_o); end
        next_cycle();
    endtask

    task automatic test_single();
        logic [IW-1:0] w;
        logic [CW-1:0] exp_d [3];
        w = 13'h1ABC;
        exp_d[0] = 5'h1C; exp_d[1] = 5'h15; exp_d[2] = 5'h06;
        data_i = w; valid_i = 1'b1; ready_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL single_accept_ready: got %b want 1", ready_o); end
        next_cycle();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b want 1", i, valid_o); end
            n_checks++; if (data_o !== exp_d[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, data_o, exp_d[i]); end
            n_checks++; if (last_o !== (i == 2)) begin n_fail++; $display("FAIL single_last[%0d]: got %b want %b", i, last_o, (i == 2)); end
            next_cycle();
        end
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b want 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL single_idle_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] exp_d [5];
        logic          rdy   [5];
        exp_d[0] = 5'h1C; exp_d[1] = 5'h15; exp_d[2] = 5'h15; exp_d[3] = 5'h15; exp_d[4] = 5'h06;
        rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1; rdy[4] = 1'b1;
        data_i = 13'h1ABC; valid_i = 1'b1; ready_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ready_i = rdy[i];
            #1;
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, valid_o); end
            n_checks++; if (data_o !== exp_d[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, data_o, exp_d[i]); end
            n_checks++; if (last_o !== (i == 4)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b want %b", i, last_o, (i == 4)); end
            next_cycle();
        end
        ready_i = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] exp_d [6];
        logic          exp_r [6];
        exp_d[0] = 5'h1F; exp_d[1] = 5'h1F; exp_d[2] = 5'h07;
        exp_d[3] = 5'h01; exp_d[4] = 5'h00; exp_d[5] = 5'h00;
        exp_r[0] = 1'b0; exp_r[1] = 1'b0; exp_r[2] = 1'b1;
        exp_r[3] = 1'b0; exp_r[4] = 1'b0; exp_r[5] = 1'b1;
        ready_i = 1'b1; data_i = 13'h1FFF; valid_i = 1'b1;
        next_cycle();
        data_i = 13'h0001;
        for (int i = 0; i < 6; i++) begin
            if (i > 2) valid_i = 1'b0;
            #1;
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_o); end
            n_checks++; if (data_o !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data_o, exp_d[i]); end
            n_checks++; if (ready_o !== exp_r[i]) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready_o, exp_r[i]); end
            n_checks++; if (last_o !== exp_r[i]) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b want %b", i, last_o, exp_r[i]); end
            next_cycle();
        end
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_clear();
        logic [IW-1:0] w2;
        ready_i = 1'b1; data_i = 13'h1ABC; valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        next_cycle();
        clear_i = 1'b1;
        #1;
        n_checks++; if (data_o !== 5'h15) begin n_fail++; $display("FAIL clear_chunk1: got %h want 15", data_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_ready_low: got %b want 0", ready_o); end
        next_cycle();
        clear_i = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_valid_drop: got %b want 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_ready_back: got %b want 1", ready_o); end
        // clear must also veto an accept offered in the same cycle
        clear_i = 1'b1; valid_i = 1'b1; data_i = 13'h1234;
        next_cycle();
        clear_i = 1'b0; valid_i = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_veto_accept: got %b want 0", valid_o); end
        w2 = 13'h0ABC;
        data_i = w2; valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (data_o !== chunk_of(w2, i)) begin n_fail++; $display("FAIL clear_next_data[%0d]: got %h want %h", i, data_o, chunk_of(w2, i)); end
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL clear_next_valid[%0d]: got %b want 1", i, valid_o); end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b1; data_i = 13'h1ABC; valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        next_cycle();
        next_cycle();
        ready_i = 1'b0;
        #1;
        n_checks++; if (last_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_last: got %b want 1", last_o); end
        #1;
        rst_i = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid_drop: got %b want 0", valid_o); end
        n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL areset_last_drop: got %b want 0", last_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL areset_data_zero: got %h want 00", data_o); end
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_no_chunk[%0d]: got %b want 0", i, valid_o); end
            next_cycle();
        end
        data_i = 13'h0F0F; valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        #1;
        n_checks++; if (data_o !== chunk_of(13'h0F0F, 0)) begin n_fail++; $display("FAIL areset_restart_data: got %h want %h", data_o, chunk_of(13'h0F0F, 0)); end
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        logic [CW-1:0] q[$];
        logic          exp_valid, exp_last, exp_ready;
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_i = 1'($urandom_range(0, 1));
            data_i  = IW'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            clear_i = ($urandom_range(0, 15) == 0);
            #1;
            exp_valid = (q.size() != 0);
            exp_last  = (q.size() == 1);
            exp_ready = (!exp_valid || (ready_i && exp_last)) && !clear_i;
            n_checks++; if (valid_o !== exp_valid) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, valid_o, exp_valid); end
            n_checks++; if (last_o !== exp_last) begin n_fail++; $display("FAIL rand_last@%0d: got %b want %b", cyc, last_o, exp_last); end
            n_checks++; if (ready_o !== exp_ready) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, ready_o, exp_ready); end
            if (exp_valid) begin
                n_checks++; if (data_o !== q[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", cyc, data_o, q[0]); end
            end
            if (clear_i) begin
                q.delete();
            end else begin
                if (exp_valid && ready_i) void'(q.pop_front());
                if (valid_i && exp_ready)
                    for (int n = 0; n < int'(NC); n++) q.push_back(chunk_of(data_i, n));
            end
            next_cycle();
        end
        clear_i = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
